// File: rtl/struct_field_arbiter.sv
// rtl/struct_field_arbiter.sv - round-robin arbiter serialising field writes into a nested packed-struct config register
//
// Purpose:
//   NUM_REQ requesters issue field-granular writes to one shared 8-bit
//   configuration register. A round-robin arbiter accepts one write at a time.
//   Each accepted write is applied one cycle later, and the new value is
//   published with a one-cycle update strobe.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   RESET_VAL  value of cfg_q after reset and after cfg_clr
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   cfg_clr    synchronous clear of the register and of any pending write
//   req_valid  per-requester write request
//   req_field  per-requester field select (2 bits each):
//              0=inner.a, 1=inner.b, 2=bar.a, 3=whole register
//   req_data   per-requester write data (8 bits each, LSB-aligned)
//   req_ready  one-hot grant/accept
//   cfg_q      register value: [7:5]=inner.a, [4:1]=inner.b, [0]=bar.a
//   upd_valid  one-cycle pulse; cfg_q has just changed because of a write
//   upd_id     index of the requester whose write produced upd_valid
//
// Optional feature (macro STRUCT_FIELD_ARBITER_PARITY_EN):
//   req_par    per-requester even parity of req_data
//   cfg_par    registered ^cfg_q
//   A write whose parity does not match is accepted but then dropped.

module struct_field_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_clr,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [2*NUM_REQ-1:0]   req_field,
    input  logic [8*NUM_REQ-1:0]   req_data,
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
    input  logic [NUM_REQ-1:0]     req_par,
    output logic                   cfg_par,
`endif
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             cfg_q,
    output logic                   upd_valid,
    output logic [2:0]             upd_id
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef struct packed {
        logic [2:0] a;
        logic [3:0] b;
    } inner_t;

    typedef struct packed {
        logic a;
    } bar_t;

    typedef struct packed {
        inner_t inner;
        bar_t   bar;
    } cfg_t;

    typedef enum logic {
        S_IDLE,
        S_COMMIT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    cfg_t             r_cfg;
    cfg_t             r_pend_img;
    logic [IDW-1:0]   r_pend_id;
    logic             r_pend_ok;
    logic [IDW-1:0]   r_last;
    logic             r_upd_valid;
    logic [2:0]       r_upd_id;

    logic             w_any;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_cand;
    logic [1:0]       w_sel_field;
    logic [7:0]       w_sel_data;
    cfg_t             w_img;
    logic             w_par_ok;
    logic             w_grant;
    logic             w_commit;

    // Index base+k, wrapped modulo NUM_REQ (k is 1..NUM_REQ).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = rr_index(r_last, k);
            if (!w_any && req_valid[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_sel_field = req_field[2*int'(w_winner) +: 2];
    assign w_sel_data  = req_data[8*int'(w_winner) +: 8];

    // The merged register image is formed at accept time. cfg_q cannot change
    // between accept and commit: only clear or reset can touch it, and both
    // discard the pending write.
    always_comb begin
        w_img = r_cfg;
        case (w_sel_field)
            2'd0:    w_img.inner.a = w_sel_data[2:0];
            2'd1:    w_img.inner.b = w_sel_data[3:0];
            2'd2:    w_img.bar.a   = w_sel_data[0];
            default: w_img         = cfg_t'(w_sel_data);
        endcase
    end

`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
    assign w_par_ok = (req_par[w_winner] == ^w_sel_data);
`else
    assign w_par_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, grant and commit.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        w_grant      = 1'b0;
        w_commit     = 1'b0;
        if (cfg_clr) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        req_ready[w_winner] = 1'b1;
                        w_grant             = 1'b1;
                        w_next_state        = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Datapath: pending capture, commit, clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg       <= cfg_t'(RESET_VAL);
            r_pend_img  <= cfg_t'(RESET_VAL);
            r_pend_id   <= '0;
            r_pend_ok   <= 1'b0;
            r_last      <= IDW'(NUM_REQ - 1);
            r_upd_valid <= 1'b0;
            r_upd_id    <= 3'd0;
        end else begin
            r_upd_valid <= 1'b0;
            if (cfg_clr) begin
                r_cfg <= cfg_t'(RESET_VAL);
            end else if (w_grant) begin
                r_pend_img <= w_img;
                r_pend_id  <= w_winner;
                r_pend_ok  <= w_par_ok;
                r_last     <= w_winner;
            end else if (w_commit && r_pend_ok) begin
                r_cfg       <= r_pend_img;
                r_upd_valid <= 1'b1;
                r_upd_id    <= 3'(r_pend_id);
            end
        end
    end

`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
    logic r_cfg_par;

    // Parity tracks cfg_q in the same cycle, so it follows every cfg_q update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_par <= ^RESET_VAL;
        end else if (cfg_clr) begin
            r_cfg_par <= ^RESET_VAL;
        end else if (w_commit && r_pend_ok) begin
            r_cfg_par <= ^r_pend_img;
        end
    end

    assign cfg_par = r_cfg_par;
`endif

    assign cfg_q     = r_cfg;
    assign upd_valid = r_upd_valid;
    assign upd_id    = r_upd_id;

endmodule

// File: tb/tb_struct_field_arbiter.sv
// tb/tb_struct_field_arbiter.sv - self-checking bench for struct_field_arbiter

module tb_struct_field_arbiter;

    localparam int         N  = 4;
    localparam logic [7:0] RV = 8'h00;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_clr;
    logic [N-1:0]     req_valid;
    logic [2*N-1:0]   req_field;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [7:0]       cfg_q;
    logic             upd_valid;
    logic [2:0]       upd_id;
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
    logic [N-1:0]     req_par;
    logic             cfg_par;
`endif

    always #5 clk = ~clk;

    struct_field_arbiter #(.NUM_REQ(N), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_clr   (cfg_clr),
        .req_valid (req_valid),
        .req_field (req_field),
        .req_data  (req_data),
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
        .req_par   (req_par),
        .cfg_par   (cfg_par),
`endif
        .req_ready (req_ready),
        .cfg_q     (cfg_q),
        .upd_valid (upd_valid),
        .upd_id    (upd_id)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register byte, pending write, round-robin last winner.
    int m_cfg;
    int m_last;
    bit m_pend;
    int m_pid;
    int m_pimg;
    bit m_pok;
    bit m_upd;
    int m_uid;
    int grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic int apply_field(input int cur, input int f, input int d);
        case (f)
            0:       return (cur & 'h1F) | ((d & 7) << 5);
            1:       return (cur & 'hE1) | ((d & 15) << 1);
            2:       return (cur & 'hFE) | (d & 1);
            default: return d & 'hFF;
        endcase
    endfunction

    function automatic bit par_ok(input int w);
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
        return req_par[w] == ^req_data[8*w +: 8];
`else
        return (w >= 0);
`endif
    endfunction

    task automatic model_reset();
        m_cfg  = RV;
        m_last = N - 1;
        m_pend = 0;
        m_pid  = 0;
        m_pimg = 0;
        m_pok  = 0;
        m_upd  = 0;
        m_uid  = 0;
    endtask

    task automatic model_edge();
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        w = m_winner();
        m_upd = 0;
        if (cfg_clr) begin
            m_cfg  = RV;
            m_pend = 0;
        end else if (m_pend) begin
            if (m_pok) begin
                m_cfg = m_pimg;
                m_upd = 1;
                m_uid = m_pid;
            end
            m_pend = 0;
        end else if (w >= 0) begin
            m_pend = 1;
            m_pid  = w;
            m_last = w;
            m_pimg = apply_field(m_cfg, int'(req_field[2*w +: 2]), int'(req_data[8*w +: 8]));
            m_pok  = par_ok(w);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] er;
        int w;
        er = '0;
        w  = m_winner();
        if (rst_n && !cfg_clr && !m_pend && w >= 0) er[w] = 1'b1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(er));
        chk({tag, ".cfg_q"},     32'(cfg_q),     32'(m_cfg[7:0]));
        chk({tag, ".upd_valid"}, 32'(upd_valid), 32'(m_upd));
        chk({tag, ".upd_id"},    32'(upd_id),    32'(m_uid[2:0]));
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
        chk({tag, ".cfg_par"},   32'(cfg_par),   32'(^m_cfg[7:0]));
`endif
    endtask

    // Inputs are set at posedge+1; outputs are compared at posedge+3.
    task automatic cycle(input string tag);
        #2;
        check_outputs(tag);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) grants.push_back(i);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_field = '0;
        req_data  = '0;
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
        req_par   = '0;
`endif
    endtask

    task automatic set_req(input int i, input logic [1:0] f, input logic [7:0] d);
        req_valid[i]       = 1'b1;
        req_field[2*i +: 2] = f;
        req_data[8*i +: 8]  = d;
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
        req_par[i]         = ^d;
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        cfg_clr = 1'b0;
        clear_reqs();
        model_reset();

        // Reset state, then 10 idle cycles.
        @(posedge clk);
        #1;
        chk("rst.cfg_q", 32'(cfg_q), 32'(RV));
        chk("rst.upd_valid", 32'(upd_valid), 0);
        chk("rst.req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) cycle("idle");

        // Whole-register write from requester 0.
        set_req(0, 2'd3, 8'hA5);
        cycle("t2_grant");
        clear_reqs();
        cycle("t2_commit");
        chk("t2.cfg_q", 32'(cfg_q), 32'h A5);
        chk("t2.upd_valid", 32'(upd_valid), 1);
        chk("t2.upd_id", 32'(upd_id), 0);
        cycle("t2_after");

        // Individual field writes from requester 1.
        set_req(1, 2'd0, 8'h03);
        cycle("t3a");
        clear_reqs();
        cycle("t3a");
        chk("t3a.cfg_q", 32'(cfg_q), 32'h65);
        set_req(1, 2'd1, 8'h0F);
        cycle("t3b");
        clear_reqs();
        cycle("t3b");
        chk("t3b.cfg_q", 32'(cfg_q), 32'h7F);
        set_req(1, 2'd2, 8'hF0);
        cycle("t3c");
        clear_reqs();
        cycle("t3c");
        chk("t3c.cfg_q", 32'(cfg_q), 32'h7E);
        chk("t3c.upd_id", 32'(upd_id), 1);

        // All requesters valid continuously: rotating grants every 2 cycles.
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, 2'd3, 8'(i));
        repeat (10) cycle("t4");
        chk("t4.ngrants", grants.size(), 5);
        for (int j = 1; j < grants.size(); j++) begin
            chk("t4.rr_order", grants[j], (grants[j-1] + 1) % N);
        end
        clear_reqs();
        cycle("t4_drain");
        cycle("t4_drain");

        // Clear during COMMIT discards the write; the pointer still advances.
        set_req(2, 2'd3, 8'h5A);
        cycle("t5_grant");
        cfg_clr = 1'b1;
        set_req(3, 2'd3, 8'h33);
        cycle("t5_clr");
        chk("t5.cfg_q", 32'(cfg_q), 32'(RV));
        chk("t5.upd_valid", 32'(upd_valid), 0);
        cfg_clr = 1'b0;
        grants.delete();
        cycle("t5_next");
        chk("t5.ngrants", grants.size(), 1);
        if (grants.size() > 0) chk("t5.next_grant", grants[0], 3);
        clear_reqs();
        cycle("t5_commit");
        chk("t5.cfg_q2", 32'(cfg_q), 32'h33);
        cycle("t5_after");

        // Reset in the middle of COMMIT.
        set_req(1, 2'd3, 8'hC3);
        cycle("rst_mid_grant");
        clear_reqs();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid.cfg_q", 32'(cfg_q), 32'(RV));
        chk("rst_mid.upd_valid", 32'(upd_valid), 0);
        cycle("rst_mid");
        rst_n = 1'b1;
        repeat (3) cycle("rst_mid_after");

`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
        // Bad parity: accepted but dropped. Good parity: applied.
        set_req(0, 2'd3, 8'h01);
        req_par[0] = 1'b0;
        cycle("t6_bad");
        clear_reqs();
        cycle("t6_bad");
        chk("t6.bad_cfg_q", 32'(cfg_q), 32'(RV));
        chk("t6.bad_upd", 32'(upd_valid), 0);
        chk("t6.bad_par", 32'(cfg_par), 32'(^RV));
        set_req(0, 2'd3, 8'h01);
        cycle("t6_good");
        clear_reqs();
        cycle("t6_good");
        chk("t6.good_cfg_q", 32'(cfg_q), 32'h01);
        chk("t6.good_par", 32'(cfg_par), 1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            clear_reqs();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_req(i, 2'($urandom_range(0, 3)), 8'($urandom));
`ifdef STRUCT_FIELD_ARBITER_PARITY_EN
                    if ($urandom_range(0, 7) == 0) req_par[i] = ~req_par[i];
`endif
                end
            end
            cfg_clr = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end
        cfg_clr = 1'b0;
        clear_reqs();
        repeat (3) cycle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/struct_field_arbiter.md
Name: struct_field_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared 8-bit configuration register built as a nested packed struct.
- The register layout is cfg_t = packed { inner: packed { a[2:0], b[3:0] }, bar: packed { a } }.
- NUM_REQ requesters issue field-granular writes over a valid/ready handshake. The block serialises the writes, applies each to the selected sub-field, and publishes the register value plus an update strobe.
- Sits between software-facing and hardware-facing config requesters and the datapath that consumes the struct.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- RESET_VAL, 8'h00, value of cfg_q on reset and on cfg_clr.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_clr  input  1  synchronous clear of register and pending write.
- req_valid  input  NUM_REQ  per-requester write request.
- req_field  input  2*NUM_REQ  per-requester field select: 0=inner.a, 1=inner.b, 2=bar.a, 3=whole register.
- req_data  input  8*NUM_REQ  per-requester write data, LSB-aligned.
- req_ready  output  NUM_REQ  one-hot grant/accept.
- cfg_q  output  8  register; bits [7:5]=inner.a, [4:1]=inner.b, [0]=bar.a.
- upd_valid  output  1  one-cycle pulse; cfg_q has just changed due to a write.
- upd_id  output  3  index of the requester whose write produced upd_valid.

Behaviour:
- Reset (async, rst_n=0) sets:
  - cfg_q=RESET_VAL, upd_valid=0, upd_id=0, req_ready=0.
  - state=IDLE.
  - rr pointer last=NUM_REQ-1, so requester 0 has highest priority first.
- FSM has two states, IDLE and COMMIT.
- IDLE:
  - If cfg_clr=0 and any req_valid is set, pick the winner: the first set bit searching from last+1 upward, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; all other ready bits are 0.
  - On the edge: capture field, data and index into the pending register, set last=winner, go to COMMIT.
  - With no valid request: stay in IDLE, ready=0.
- COMMIT:
  - req_ready=0.
  - On the edge, apply the pending write to cfg_q, set upd_valid=1 and upd_id=pending index, then go to IDLE.
- Field write rules; untouched bits are preserved and unused data bits are ignored:
  - field 0: inner.a <= data[2:0].
  - field 1: inner.b <= data[3:0].
  - field 2: bar.a <= data[0].
  - field 3: cfg_q <= data[7:0].
- Latency:
  - Handshake in cycle T makes the new cfg_q and upd_valid visible in cycle T+2.
  - upd_valid is high for exactly one cycle.
  - Maximum throughput is one write per 2 cycles.
- A write whose value equals the current cfg_q still pulses upd_valid.
- cfg_clr=1, any state:
  - req_ready forced to 0.
  - On the edge: cfg_q=RESET_VAL, pending write discarded, state=IDLE, upd_valid=0.
  - The rr pointer is unchanged.
  - cfg_clr has priority over a COMMIT in the same cycle.
- A requester that drops valid before ready has no effect. A requester holding valid is guaranteed a grant within NUM_REQ grants.
- Reset mid-COMMIT discards the pending write; cfg_q returns to RESET_VAL.
- Implementation holds cfg_q and the pending data as the nested packed struct type, with field updates by member access (no manual bit slicing).

Optional Feature:
- Macro: STRUCT_FIELD_ARBITER_PARITY_EN.
- When defined:
  - Adds output cfg_par (1 bit), registered, always equal to ^cfg_q, including after reset and cfg_clr.
  - Adds input req_par (NUM_REQ bits), the even parity of the requester's req_data[7:0] as written.
  - A captured write whose parity mismatches is dropped in COMMIT: cfg_q unchanged, upd_valid=0. The requester still sees req_ready.
- When undefined: neither port exists and all writes are applied.

Test Plan:
1. Reset release, no requests -> cfg_q=8'h00, upd_valid=0, req_ready=0 for 10 cycles.
2. req0 field 3, data 8'hA5 -> req_ready[0]=1 in cycle T, cfg_q=8'hA5 and upd_valid=1, upd_id=0 in cycle T+2.
3. From cfg_q=8'hA5:
   - req1 field 0, data 3'b011 -> cfg_q=8'h65.
   - Then req1 field 1, data 4'hF -> cfg_q=8'h7F.
   - Then req1 field 2, data 0 -> cfg_q=8'h7E.
4. req0..req3 all valid continuously, field 3, data = index -> grants in order 0,1,2,3,0 every 2 cycles; upd_id follows the same sequence.
5. req2 accepted, cfg_clr=1 in the COMMIT cycle -> cfg_q=8'h00, no upd_valid. The next grant after clr goes to req3 if req2 and req3 are both valid.
6. With parity enabled, req0 data 8'h01, req_par=0 -> no change, upd_valid=0, cfg_par unchanged. The same write with req_par=1 -> cfg_q=8'h01, cfg_par=1.
